// File: rtl/instr_mem_param.sv
// Parametrised instruction RAM. After reset it clears itself to NOP_WORD,
// one word per cycle. It is then loaded through the program port and read
// through a fetch port with one cycle of latency.
module instr_mem_param #(
   parameter int              XLEN     = 32,
   parameter int              DEPTH    = 32,
   parameter int              ADDR_W   = 32,
   parameter logic [XLEN-1:0] NOP_WORD = XLEN'(32'h00000013)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              fetch_req,
   input  logic [ADDR_W-1:0] fetch_addr,
   output logic              fetch_ready,
   output logic              instr_valid,
   output logic [XLEN-1:0]   instruction,
   output logic              instr_fault,
   input  logic              prog_we,
   input  logic [ADDR_W-1:0] prog_addr,
   input  logic [XLEN-1:0]   prog_data,
   output logic              prog_ack,
   output logic              prog_err,
   output logic              init_busy
);

   localparam int IDX_W = $clog2(DEPTH);
   // Compare the whole word index against DEPTH, so high address bits can never alias.
   localparam logic [ADDR_W-3:0] DEPTH_IDX = (ADDR_W-2)'(DEPTH);

   typedef enum logic {S_INIT, S_READY} state_t;

   state_t            state_q, state_d;
   logic [IDX_W-1:0]  cnt_q, cnt_d;
   logic              instr_valid_q, instr_valid_d;
   logic              instr_fault_q, instr_fault_d;
   logic [XLEN-1:0]   instruction_q, instruction_d;
   logic              prog_ack_q, prog_ack_d;
   logic              prog_err_q, prog_err_d;

   logic [XLEN-1:0]   mem_q [DEPTH];
   logic              mem_we;
   logic [IDX_W-1:0]  mem_waddr;
   logic [XLEN-1:0]   mem_wdata;

   logic              fetch_ok, prog_ok;
   logic [IDX_W-1:0]  fetch_idx, prog_idx;

   // Decode addresses into word indices and check them for legality.
   always_comb begin
      fetch_ok  = (fetch_addr[1:0] == 2'b00) && (fetch_addr[ADDR_W-1:2] < DEPTH_IDX);
      prog_ok   = (prog_addr[1:0] == 2'b00) && (prog_addr[ADDR_W-1:2] < DEPTH_IDX);
      fetch_idx = fetch_addr[IDX_W+1:2];
      prog_idx  = prog_addr[IDX_W+1:2];
   end

   // Next-state logic for the FSM and the registered outputs. In INIT the clear
   // sequence owns the write port, and fetch and program requests are ignored.
   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      instr_valid_d = 1'b0;
      instr_fault_d = 1'b0;
      instruction_d = instruction_q;
      prog_ack_d    = 1'b0;
      prog_err_d    = 1'b0;
      mem_we        = 1'b0;
      mem_waddr     = cnt_q;
      mem_wdata     = NOP_WORD;
      case (state_q)
         S_INIT: begin
            mem_we = 1'b1;
            cnt_d  = cnt_q + 1'b1;
            if (cnt_q == IDX_W'(DEPTH - 1)) state_d = S_READY;
         end
         default: begin
            if (fetch_req) begin
               instr_valid_d = 1'b1;
               instr_fault_d = !fetch_ok;
               // The read is asynchronous, so a write to the same word in this
               // cycle is not yet visible: the fetch returns the old contents.
               instruction_d = fetch_ok ? mem_q[fetch_idx] : NOP_WORD;
            end
            if (prog_we) begin
               mem_we     = prog_ok;
               mem_waddr  = prog_idx;
               mem_wdata  = prog_data;
               prog_ack_d = prog_ok;
               prog_err_d = !prog_ok;
            end
         end
      endcase
      // A cycle that has reset asserted must not modify memory.
      if (reset) mem_we = 1'b0;
   end

   // Control and output registers, with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= S_INIT;
         cnt_q         <= '0;
         instr_valid_q <= 1'b0;
         instr_fault_q <= 1'b0;
         instruction_q <= NOP_WORD;
         prog_ack_q    <= 1'b0;
         prog_err_q    <= 1'b0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         instr_valid_q <= instr_valid_d;
         instr_fault_q <= instr_fault_d;
         instruction_q <= instruction_d;
         prog_ack_q    <= prog_ack_d;
         prog_err_q    <= prog_err_d;
      end
   end

   // Storage array. It has no reset; the INIT sweep clears it.
   always_ff @(posedge clk) begin
      if (mem_we) mem_q[mem_waddr] <= mem_wdata;
   end

   assign fetch_ready = (state_q == S_READY);
   assign init_busy   = (state_q == S_INIT);
   assign instr_valid = instr_valid_q;
   assign instr_fault = instr_fault_q;
   assign instruction = instruction_q;
   assign prog_ack    = prog_ack_q;
   assign prog_err    = prog_err_q;

endmodule
